// File: rtl/seq_div_64.sv
// rtl/seq_div_64.sv - 64-bit unsigned restoring divider, one quotient bit per cycle.
// Optional macro SEQ_DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes in one cycle.
module seq_div_64 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] A,
   input  logic [63:0] B,
   output logic [63:0] Q,
   output logic [63:0] R,
   output logic        busy,
   output logic        done,
   output logic        dz
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [63:0] dvd_q;      // dividend bits shift out of the top, quotient bits shift in at the bottom
   logic [63:0] rem;
   logic [63:0] dvs;
   logic [6:0]  cnt;
   logic        dz_r;

   logic        accept;
   logic        zero_fast;
   logic        last_iter;

   logic [63:0] rem_low;
   logic [64:0] low_sum;
   logic        no_borrow;
   logic [63:0] rem_next;

   // The 65-bit partial remainder is {rem[63], rem_low}. Its subtraction of {1'b0, dvs} is split so
   // the top bit's carry-out reduces to rem[63] | carry-out of the low 64-bit complement add.
   assign rem_low   = {rem[62:0], dvd_q[63]};
   assign low_sum   = {1'b0, rem_low} + {1'b0, ~dvs} + 65'd1;
   assign no_borrow = rem[63] | low_sum[64];
   assign rem_next  = no_borrow ? low_sum[63:0] : rem_low;
   assign last_iter = (cnt == 7'd63);

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      zero_fast  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
`ifdef SEQ_DIV_ZERO_FAST_EN
               if (B == 64'd0) begin
                  zero_fast  = 1'b1;
                  state_next = DONE;
               end
`endif
            end
         end
         DONE: begin
            state_next = IDLE;
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
`ifdef SEQ_DIV_ZERO_FAST_EN
               if (B == 64'd0) begin
                  zero_fast  = 1'b1;
                  state_next = DONE;
               end
`endif
            end
         end
         RUN: begin
            if (last_iter) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dvd_q <= 64'd0;
         rem   <= 64'd0;
         dvs   <= 64'd0;
         cnt   <= 7'd0;
         dz_r  <= 1'b0;
      end else if (accept) begin
         dvs  <= B;
         cnt  <= 7'd0;
         dz_r <= (B == 64'd0);
         if (zero_fast) begin
            dvd_q <= '1;
            rem   <= A;
         end else begin
            dvd_q <= A;
            rem   <= 64'd0;
         end
      end else if (state == RUN) begin
         dvd_q <= {dvd_q[62:0], no_borrow};
         rem   <= rem_next;
         if (!last_iter) begin
            cnt <= cnt + 7'd1;
         end
      end
   end

   assign Q  = dvd_q;
   assign R  = rem;
   assign dz = dz_r;

endmodule
